uart_rx_fsm: RTL and testbench

Frame controller for the UART receiver. It detects the start condition on RX_IN and enables the edge/bit counter and data sampler. It walks the frame (start, 8 data bits, optional parity, stop), deserializes the sampled bits LSB-first, checks start/parity/stop, and emits one validated byte per frame.
It sits between the RX oversampling front end (edge/bit counter plus data sampler) and the register-file/SYS-control side.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_fsm_if.sv | 42 ++++
 rtl/uart_rx_deser.sv | 47 ++++
 rtl/uart_rx_fsm.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and constants for the UART receive frame
//                controller: state encoding and frame bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Payload bits per frame; the external counter wraps at bit_cnt 9/10,
    // so only 8 is supported.
    localparam int DATA_WIDTH = 8;

    // bit_cnt values reported by the edge/bit counter
    localparam logic [3:0] START_IDX     = 4'd0;
    localparam logic [3:0] LAST_DATA_IDX = 4'd8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fsm_if
//  Description : Signal bundle between the RX frame controller, the
//                oversampling front end (counter + sampler) and the
//                register-file side.
//                  slave  : frame controller view
//                  master : environment view (front end + consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;        // serial line, idle high
    logic [PRESCALE_W-1:0] Prescale;     // oversampling ratio 8/16/32
    logic                  PAR_EN;       // parity bit present
    logic                  PAR_TYP;      // 0 even, 1 odd
    logic [3:0]            bit_cnt;      // frame bit index from counter
    logic [EDGE_W-1:0]     edge_cnt;     // edge index inside current bit
    logic                  sampled_bit;  // majority-voted bit from sampler
    logic                  edge_bit_en;  // counter enable
    logic                  dat_samp_en;  // sampler enable
    logic [DATA_WIDTH-1:0] P_DATA;       // last good byte
    logic                  data_valid;   // pulse: P_DATA updated
    logic                  par_err;      // pulse: frame dropped, parity
    logic                  stp_err;      // pulse: frame dropped, stop bit
    logic                  busy;         // not idle

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, bit_cnt, edge_cnt, sampled_bit,
        output edge_bit_en, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
    );

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, bit_cnt, edge_cnt, sampled_bit,
        input  edge_bit_en, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
    );

endinterface : uart_rx_fsm_if
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deser
//  Description : LSB-first deserializer for the RX data bits plus the
//                parity reduction of the collected byte.
//  Ports       : CLK, RST      - clock, synchronous active-high reset
//                shift_en      - shift sampled_bit in at the MSB end
//                sampled_bit   - bit to shift in
//                sr            - current shift register contents
//                par_calc      - XOR reduction of sr
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deser
    import uart_rx_pkg::*;
(
    input  wire logic                  CLK,
    input  wire logic                  RST,
    input  wire logic                  shift_en,
    input  wire logic                  sampled_bit,
    output logic      [DATA_WIDTH-1:0] sr,
    output logic                       par_calc
);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] sr_d;

    // First received bit ends up in bit 0 after DATA_WIDTH shifts.
    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            sr_d = {sampled_bit, sr_q[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr       = sr_q;
    assign par_calc = ^sr_q;

endmodule : uart_rx_deser
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fsm
//  Description : UART receive frame controller. Detects the start
//                condition, enables the edge/bit counter and sampler,
//                walks start/data/parity/stop, checks the frame and emits
//                one validated byte (or one error pulse) per frame.
//  Ports       : CLK, RST      - clock, synchronous active-high reset
//                bus (slave)   - RX_IN, Prescale, PAR_EN, PAR_TYP,
//                                bit_cnt, edge_cnt, sampled_bit in;
//                                edge_bit_en, dat_samp_en, P_DATA,
//                                data_valid, par_err, stp_err, busy out
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  wire logic    CLK,
    input  wire logic    RST,
    uart_rx_fsm_if.slave bus
);

    rx_state_e             state_q, state_d;
    logic                  par_fail_q, par_fail_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  bit_end;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] sr;
    logic                  par_calc;

    // Last oversampling edge of the current bit: every frame decision is
    // taken on the clock edge that closes a bit.
    assign bit_end = (state_q != IDLE) &&
                     (PRESCALE_W'(bus.edge_cnt) == (bus.Prescale - PRESCALE_W'(1)));

    uart_rx_deser u_deser (
        .CLK         (CLK),
        .RST         (RST),
        .shift_en    (shift_en),
        .sampled_bit (bus.sampled_bit),
        .sr          (sr),
        .par_calc    (par_calc)
    );

    always_comb begin
        state_d      = state_q;
        par_fail_d   = par_fail_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        shift_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d    = START;
                    par_fail_d = 1'b0;
                end
            end
            START: begin
                // A high sample at the end of the start bit is a glitch.
                if (bit_end) begin
                    state_d = bus.sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    // >= keeps the walk moving if the counter ever overshoots
                    if (bus.bit_cnt >= LAST_DATA_IDX) begin
                        state_d = bus.PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_fail_d = bus.sampled_bit ^ par_calc ^ bus.PAR_TYP;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A bad stop bit outranks a parity failure.
                    if (!bus.sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (par_fail_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = sr;
                        data_valid_d = 1'b1;
                    end
                    // Line already low: next start bit follows without a gap.
                    if (!bus.RX_IN) begin
                        state_d    = START;
                        par_fail_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            par_fail_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_fail_q   <= par_fail_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.edge_bit_en = (state_q != IDLE);
    assign bus.dat_samp_en = (state_q != IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.P_DATA      = p_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;

endmodule : uart_rx_fsm
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fsm
//  Description : Self-checking bench for uart_rx_fsm. Models the edge/bit
//                counter and sampler, drives directed frames, and checks
//                every cycle against a frame-level timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_fsm_if bus ();

    uart_rx_fsm #(.PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // One entry per frame: busy for cycles [s, s+len), outcome pulse in the
    // cycle after edge s+len. kind: 0 none, 1 valid, 2 parity, 3 stop.
    typedef struct {
        int         s;
        int         len;
        int         kind;
        logic [7:0] d;
    } frame_t;

    frame_t      q[$];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_pdata  = 8'h00;
    bit          chk_en   = 1'b0;
    logic [15:0] fbits    = 16'hFFFF;
    int          last_s   = 0;
    int          last_end = 0;
    int          dv_cnt   = 0;
    int          pe_cnt   = 0;
    int          se_cnt   = 0;
    int          dv_last  = -1000000;
    int          dv_prev  = -1000000;

    // cycle following edge e sees cyc == e
    always @(posedge CLK) cyc <= cyc + 1;

    // Edge/bit counter front end: runs while enabled, wraps after the last bit.
    always @(posedge CLK) begin
        if (RST || !bus.edge_bit_en) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (int'(bus.edge_cnt) == int'(bus.Prescale) - 1) begin
            bus.edge_cnt <= '0;
            if (int'(bus.bit_cnt) == (bus.PAR_EN ? 10 : 9)) bus.bit_cnt <= '0;
            else                                            bus.bit_cnt <= bus.bit_cnt + 4'd1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + 5'd1;
        end
    end

    // Ideal sampler: the voted value of the bit currently being counted.
    assign bus.sampled_bit = fbits[bus.bit_cnt];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the frame timeline.
    initial begin
        logic        e_busy;
        int          e_kind;
        logic [13:0] e_vec;
        logic [13:0] a_vec;
        forever begin
            @(posedge CLK);
            #3;
            if (chk_en) begin
                e_busy = 1'b0;
                e_kind = 0;
                foreach (q[i]) begin
                    if (cyc >= q[i].s && cyc < q[i].s + q[i].len) e_busy = 1'b1;
                    if (cyc == q[i].s + q[i].len) begin
                        e_kind = q[i].kind;
                        if (q[i].kind == 1) m_pdata = q[i].d;
                    end
                end
                while (q.size() > 0 && q[0].s + q[0].len < cyc) void'(q.pop_front());
                e_vec = {e_busy, e_busy, e_busy, e_kind == 1, e_kind == 2, e_kind == 3, m_pdata};
                a_vec = {bus.busy, bus.edge_bit_en, bus.dat_samp_en,
                         bus.data_valid, bus.par_err, bus.stp_err, bus.P_DATA};
                chk($sformatf("outputs@%0d", cyc), 32'(a_vec), 32'(e_vec));
                if (bus.data_valid === 1'b1) begin
                    dv_prev = dv_last;
                    dv_last = cyc;
                    dv_cnt++;
                end
                if (bus.par_err === 1'b1) pe_cnt++;
                if (bus.stp_err === 1'b1) se_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame. started=1: the start edge already happened (the
    // previous frame left RX_IN low at its stop decision). abort_at >= 0
    // asserts RST in that cycle of the frame instead of finishing it.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_bit,
                              input bit started, input bit b2b_next, input int abort_at);
        int          p;
        int          nb;
        logic        par_bit;
        logic [15:0] bits;
        frame_t      f;
        p       = int'(bus.Prescale);
        nb      = bus.PAR_EN ? 11 : 10;
        par_bit = (^d) ^ bus.PAR_TYP;
        if (!par_ok) par_bit = ~par_bit;
        bits      = 16'hFFFF;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (bus.PAR_EN) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end
        f.kind = !stop_bit ? 3 : ((bus.PAR_EN && !par_ok) ? 2 : 1);
        f.len  = nb * p;
        f.d    = d;
        if (!started) begin
            @(negedge CLK);
            bus.RX_IN = 1'b0;
            f.s = cyc + 1;
        end else begin
            f.s = last_end;
        end
        q.push_back(f);
        last_s   = f.s;
        last_end = f.s + f.len;
        if (!started) @(posedge CLK);
        for (int k = 0; k < nb * p; k++) begin
            @(negedge CLK);
            if (k == 0) fbits = bits;
            if (k == abort_at) begin
                bus.RX_IN = 1'b1;
                RST       = 1'b1;
                q.delete();
                m_pdata   = 8'h00;
                @(negedge CLK);
                RST = 1'b0;
                return;
            end
            if (k == nb * p - 1) bus.RX_IN = b2b_next ? 1'b0 : 1'b1;
            else                 bus.RX_IN = bits[k / p];
            @(posedge CLK);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n_dv;
        int     n_pe;
        int     n_se;
        frame_t g;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        RST          = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_en = 1'b1;
        chk("reset_outputs", 32'({bus.busy, bus.edge_bit_en, bus.dat_samp_en, bus.data_valid,
                                  bus.par_err, bus.stp_err, bus.P_DATA}), 32'd0);
        RST = 1'b0;
        idle(2);

        // Prescale 8, no parity, 0xA5
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        chk("a5_latency", 32'(dv_last - last_s), 32'd80);
        chk("a5_pdata", 32'(bus.P_DATA), 32'h0A5);

        // Prescale 16, even parity, 0x3C good then bad parity
        bus.Prescale = 6'd16;
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b0;
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        chk("3c_latency", 32'(dv_last - last_s), 32'd176);
        chk("3c_pdata", 32'(bus.P_DATA), 32'h03C);
        n_dv = dv_cnt;
        n_pe = pe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        chk("badpar_pe_count", 32'(pe_cnt - n_pe), 32'd1);
        chk("badpar_no_dv", 32'(dv_cnt - n_dv), 32'd0);
        chk("badpar_pdata_held", 32'(bus.P_DATA), 32'h03C);

        // Prescale 8, odd parity: stop error outranks a parity error
        bus.Prescale = 6'd8;
        bus.PAR_TYP  = 1'b1;
        idle(2);
        n_pe = pe_cnt;
        n_se = se_cnt;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(2);
        chk("stop_se_count", 32'(se_cnt - n_se), 32'd1);
        chk("stop_no_pe", 32'(pe_cnt - n_pe), 32'd0);
        chk("stop_idle", 32'(bus.busy), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        chk("81_pdata", 32'(bus.P_DATA), 32'h081);

        // Start glitch: RX_IN low for 2 cycles
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        idle(2);
        n_dv = dv_cnt;
        @(negedge CLK);
        bus.RX_IN = 1'b0;
        fbits     = 16'hFFFF;
        g.s = cyc + 1; g.len = 8; g.kind = 0; g.d = 8'h00;
        q.push_back(g);
        last_s = g.s;
        @(negedge CLK);
        @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (7) @(negedge CLK);
        chk("glitch_cycle", 32'(cyc - last_s), 32'd8);
        chk("glitch_busy", 32'(bus.busy), 32'd0);
        chk("glitch_no_pulse", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
        idle(2);

        // Prescale 32, back-to-back 0x55 then 0xFF
        bus.Prescale = 6'd32;
        idle(2);
        n_dv = dv_cnt;
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        idle(3);
        chk("b2b_dv_count", 32'(dv_cnt - n_dv), 32'd2);
        chk("b2b_gap", 32'(dv_last - dv_prev), 32'd320);
        chk("b2b_pdata", 32'(bus.P_DATA), 32'h0FF);

        // Reset mid-DATA of 0x12, then 0x34
        bus.Prescale = 6'd8;
        idle(2);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 35);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_edge_en", 32'(bus.edge_bit_en), 32'd0);
        chk("rst_pdata", 32'(bus.P_DATA), 32'd0);
        idle(3);
        send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        chk("34_pdata", 32'(bus.P_DATA), 32'h034);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_fsm
`default_nettype wire
